// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
//  imem_pkg
//  Shared fetch-path types and defaults common to imem_fetch_ctrl and instr_mem.
//  Rev 1.0
// ============================================================================
package imem_pkg;

    localparam int unsigned C_ADDR_WIDTH = 8;
    localparam int unsigned C_DATA_WIDTH = 12;
    localparam int unsigned C_RESET_PC   = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
//  fetch_skid_buf
//  Two-entry {pc, instr} FIFO; slot 0 is the registered head seen by decode.
//  Rev 1.0
// ============================================================================
module fetch_skid_buf #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    input  logic [DATA_WIDTH-1:0] i_instr,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic                  o_can_push,
    output logic [1:0]            o_count
);

    logic [ADDR_WIDTH-1:0] r_pc0, r_pc1;
    logic [DATA_WIDTH-1:0] r_instr0, r_instr1;
    logic [1:0]            r_count;
    logic                  w_pop;
    logic                  w_push;

    assign o_valid    = (r_count != 2'd0);
    assign w_pop      = o_valid & i_ready;
    assign o_can_push = (r_count != 2'd2) | w_pop;
    assign w_push     = i_push & o_can_push;
    assign o_pc       = r_pc0;
    assign o_instr    = r_instr0;
    assign o_count    = r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count  <= 2'd0;
            r_pc0    <= '0;
            r_pc1    <= '0;
            r_instr0 <= '0;
            r_instr1 <= '0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            unique case ({w_push, w_pop})
                2'b01: begin
                    r_pc0    <= r_pc1;
                    r_instr0 <= r_instr1;
                    r_count  <= r_count - 2'd1;
                end
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_pc0    <= i_pc;
                        r_instr0 <= i_instr;
                    end else begin
                        r_pc1    <= i_pc;
                        r_instr1 <= i_instr;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop: incoming word lands behind whatever survives the pop.
                    if (r_count == 2'd1) begin
                        r_pc0    <= i_pc;
                        r_instr0 <= i_instr;
                    end else begin
                        r_pc0    <= r_pc1;
                        r_instr0 <= r_instr1;
                        r_pc1    <= i_pc;
                        r_instr1 <= i_instr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  imem_fetch_ctrl
//  Fetch PC sequencer with redirect, halt/drain control and prefetch buffer.
//  Rev 1.0
// ============================================================================
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = C_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = C_DATA_WIDTH,
    parameter int unsigned RESET_PC   = C_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt_req,
    output logic                  halted
);

    localparam logic [ADDR_WIDTH-1:0] C_PC_INIT = RESET_PC[ADDR_WIDTH-1:0];

    fetch_state_t          r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic                  w_push;
    logic                  w_can_push;
    logic                  w_drained;
    logic [1:0]            w_count;

    // Empty after this edge, accounting for a pop happening right now.
    assign w_drained = (w_count == 2'd0) | ((w_count == 2'd1) & out_valid & out_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!redirect_valid) begin
                    if (halt_req)      w_state_next = ST_HALTED;
                    else if (fetch_en) w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!redirect_valid) begin
                    w_push = w_can_push;
                    if (halt_req) w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (redirect_valid || w_drained) w_state_next = ST_HALTED;
            end
            ST_HALTED: begin
                if (!redirect_valid && !halt_req && fetch_en) w_state_next = ST_RUN;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= C_PC_INIT;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + 1'b1;
        end
    end

    fetch_skid_buf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_flush    (redirect_valid),
        .i_push     (w_push),
        .i_pc       (r_fetch_pc),
        .i_instr    (imem_instr),
        .i_ready    (out_ready),
        .o_valid    (out_valid),
        .o_pc       (out_pc),
        .o_instr    (out_instr),
        .o_can_push (w_can_push),
        .o_count    (w_count)
    );

    assign imem_addr = r_fetch_pc;
    assign halted    = (r_state == ST_HALTED);

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_imem_fetch_ctrl
//  Scoreboarded bench: accepted words must be consecutive PCs from the last restart.
//  Rev 1.0
// ============================================================================
module tb_imem_fetch_ctrl;

    localparam int AW = 8;
    localparam int DW = 12;
    localparam logic [AW-1:0] RPC = '0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fetch_en;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_instr;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          halt_req;
    logic          halted;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RESET_PC   (0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    assign imem_instr = mem[imem_addr];

    int checks  = 0;
    int errors  = 0;
    int accepts = 0;

    logic [AW+DW-1:0] exp_q [$];

    function automatic logic [DW-1:0] ref_instr(input logic [AW-1:0] pc);
        return DW'(12'h100 + {4'h0, pc});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected accepted stream after a reset or redirect: start, start+1, ... mod 2^AW.
    task automatic restart(input logic [AW-1:0] pc);
        logic [AW-1:0] p;
        exp_q.delete();
        for (int k = 0; k < 1024; k++) begin
            p = pc + k[AW-1:0];
            exp_q.push_back({p, ref_instr(p)});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic             prev_hold = 1'b0;
    logic [AW-1:0]    prev_pc;
    logic [DW-1:0]    prev_instr;
    logic [AW+DW-1:0] e;

    always @(negedge clk) begin
        if (rst_n && prev_hold && out_valid) begin
            chk("hold_pc", 32'(out_pc), 32'(prev_pc));
            chk("hold_instr", 32'(out_instr), 32'(prev_instr));
        end
        if (rst_n && halted) chk("halted_empty", 32'(out_valid), 32'd0);
        if (rst_n && out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got pc 0x%0h, expected none", out_pc);
            end else begin
                e = exp_q.pop_front();
                chk("acc_pc", 32'(out_pc), 32'(e[AW+DW-1:DW]));
                chk("acc_instr", 32'(out_instr), 32'(e[DW-1:0]));
                accepts++;
            end
        end
        prev_hold  = rst_n && out_valid && !out_ready && !redirect_valid;
        prev_pc    = out_pc;
        prev_instr = out_instr;
    end

    task automatic do_redirect(input logic [AW-1:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        restart(pc);
        step();
        redirect_valid = 1'b0;
    endtask

    logic [AW-1:0] addr_snap;
    int            r;
    bit            got;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(12'h100 + i);
        rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0;
        restart(RPC);
        repeat (3) step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'(RPC));
        chk("rst_pc", 32'(out_pc), 32'd0);
        chk("rst_instr", 32'(out_instr), 32'd0);

        rst_n = 1'b1;
        step();
        chk("idle_addr", 32'(imem_addr), 32'(RPC));
        chk("idle_valid", 32'(out_valid), 32'd0);

        // Startup latency: valid two edges after fetch_en.
        fetch_en = 1'b1; out_ready = 1'b1;
        step();
        chk("start_e0_valid", 32'(out_valid), 32'd0);
        step();
        chk("start_e1_valid", 32'(out_valid), 32'd1);
        chk("start_e1_pc", 32'(out_pc), 32'd0);
        repeat (4) step();
        chk("pre_stall_pc", 32'(out_pc), 32'd4);

        out_ready = 1'b0;
        repeat (5) step();
        chk("stall_pc", 32'(out_pc), 32'd4);
        chk("stall_addr", 32'(imem_addr), 32'd6);
        chk("stall_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        repeat (3) step();

        // Redirect with a full buffer: one bubble then the target.
        out_ready = 1'b0;
        repeat (3) step();
        do_redirect(8'h40);
        chk("redir_bubble", 32'(out_valid), 32'd0);
        chk("redir_addr", 32'(imem_addr), 32'h40);
        out_ready = 1'b1;
        step();
        chk("redir_valid", 32'(out_valid), 32'd1);
        chk("redir_pc", 32'(out_pc), 32'h40);
        repeat (3) step();

        do_redirect(8'hFE);
        step();
        chk("wrap_first", 32'(out_pc), 32'hFE);
        repeat (6) step();

        // Halt with a full buffer, then redirect while halted and resume.
        out_ready = 1'b0;
        repeat (3) step();
        halt_req = 1'b1; out_ready = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            step();
            got = halted;
        end
        chk("halt_reached", 32'(halted), 32'd1);
        addr_snap = imem_addr;
        repeat (3) step();
        chk("halt_addr_hold", 32'(imem_addr), 32'(addr_snap));
        chk("halt_valid", 32'(out_valid), 32'd0);
        do_redirect(8'h10);
        chk("halt_redir_state", 32'(halted), 32'd1);
        chk("halt_redir_addr", 32'(imem_addr), 32'h10);
        halt_req = 1'b0;
        step();
        chk("resume_halted", 32'(halted), 32'd0);
        step();
        chk("resume_valid", 32'(out_valid), 32'd1);
        chk("resume_pc", 32'(out_pc), 32'h10);
        repeat (4) step();

        // One-cycle reset with a full buffer.
        out_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        restart(RPC);
        step();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_addr", 32'(imem_addr), 32'(RPC));
        chk("mid_rst_halted", 32'(halted), 32'd0);
        rst_n = 1'b1; out_ready = 1'b1;
        repeat (2) step();
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_pc", 32'(out_pc), 32'(RPC));

        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 999));
            out_ready      = ($urandom_range(0, 3) != 0);
            fetch_en       = ($urandom_range(0, 9) != 0);
            redirect_valid = 1'b0;
            rst_n          = 1'b1;
            if (r < 30) begin
                redirect_valid = 1'b1;
                redirect_pc    = AW'($urandom_range(0, (1 << AW) - 1));
                restart(redirect_pc);
            end else if (r < 45) begin
                halt_req = ~halt_req;
            end else if (r == 999) begin
                rst_n = 1'b0;
                restart(RPC);
            end
            step();
        end
        redirect_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("progress", 32'(accepts > 300), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
